reduction_pipe: RTL and testbench
=================================

Name: reduction_pipe

Overview:
Parametrised, pipelined successor to the 16-bit combinational reduction unit (RED). It sums all SEG_W-wide segments of two DATA_W operands through a registered adder tree, one tree level per stage. It supports a per-transaction signed/unsigned mode and a valid/ready handshake with backpressure. It sits in the execute stage beside the ALU as a multi-cycle functional unit with full throughput (one operation per cycle).

Parameters:
DATA_W, 16, operand width in bits; must be a multiple of SEG_W.
SEG_W, 4, segment width in bits.
N (localparam), 2*DATA_W/SEG_W, total segment count; must be a power of two and at least 2.
L (localparam), clog2(N), pipeline depth, equal to the latency in cycles.
RES_W (localparam), SEG_W+L, reduced result width (7 at defaults).

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst  in  1  asynchronous active-high reset.
in_valid  in  1  operands and mode are valid this cycle.
in_ready  out  1  the unit accepts input this cycle.
rs  in  DATA_W  operand A; segment i is rs[i*SEG_W +: SEG_W].
rt  in  DATA_W  operand B, segmented the same way.
sgn  in  1  1 = segments are two's-complement, 0 = segments are unsigned.
out_valid  out  1  rd and rd_ext hold a result.
out_ready  in  1  downstream accepts the result.
rd  out  RES_W  sum of all N segments.
rd_ext  out  DATA_W  rd sign-extended (sgn=1) or zero-extended (sgn=0) to DATA_W.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous, active-high.
- Reset values: all stage valid bits 0, all partial sums 0, carried mode bits 0. Hence out_valid=0, rd=0, rd_ext=0, and in_ready=1 once rst deasserts.
- Operation: every segment is extended to RES_W bits, sign-extended when sgn=1 and zero-extended when sgn=0. All N extended segments are summed. The sum always fits in RES_W bits, so no overflow or saturation logic is needed.
- Stage k (k=1..L) registers N/2^k partial sums, each SEG_W+k bits wide, plus v[k] and mode[k].
- Stage 1 extends the segments and adds adjacent pairs: segment 2j + segment 2j+1, with rs segments at indices 0..N/2-1 and rt segments at N/2..N-1.
- Stage L holds the single final sum. rd = stage L sum; rd_ext is extended using mode[L].
- Advance signal: advance = !(v[L] && !out_ready).
- When advance is 1, every stage shifts forward, with v[1] <= in_valid && in_ready.
- When advance is 0, all stages hold, including the bubbles behind the stalled result.
- in_ready = advance. This is a combinational path from out_ready; accept it for this unit.
- Handshakes: transfer-in occurs when in_valid && in_ready; transfer-out occurs when out_valid && out_ready.
- Latency: a result is accepted at edge t and appears with out_valid=1 after edge t+L-1. That is L cycles at the output, and 3 cycles at the defaults.
- Throughput: one result per cycle while out_ready=1.
- Stability: while out_valid && !out_ready, rd, rd_ext and out_valid hold stable.
- in_valid=0 inserts a bubble. Bubble stages may keep stale sums, but the corresponding v bit must be 0.
- Simultaneous transfer-out and transfer-in in the same cycle is legal and must be lossless.
- Reset mid-operation: all in-flight results are discarded immediately (asynchronous) and out_valid drops to 0 without waiting for a clock edge.
- Defaults: at DATA_W=16, SEG_W=4, rd is bit-identical to the existing 7-bit RED result for unsigned operands.

Decomposition:
- Shared package: the RED opcode constant, and functions computing clog2 and RES_W from (DATA_W, SEG_W) so that decode and writeback size consistently.
- One sub-module: red_add_level. It is parametrised by input count and input width, and registers pairwise sums together with their valid and mode bits under an enable.
- reduction_pipe instantiates L red_add_level stages through a generate loop and adds the extension and handshake glue.

Test Plan:
1. Defaults, sgn=0, rs=16'h1234, rt=16'h5678, out_ready=1 -> out_valid rises 3 cycles after acceptance; rd=7'd36, rd_ext=16'h0024.
2. rs=rt=16'hFFFF, first with sgn=0 then with sgn=1 -> rd=7'h78 in both cases; rd_ext=16'h0078 for sgn=0 and 16'hFFF8 for sgn=1. Then rs=rt=16'h8888 with sgn=1 -> rd=7'h40, rd_ext=16'hFFC0.
3. Stream of 8 back-to-back random operations with out_ready=1 -> 8 consecutive out_valid cycles, in order, each matching a software nibble-sum model.
4. Backpressure: hold out_ready=0 for 5 cycles while a stream is in flight -> in_ready=0, and rd stays stable throughout. On release, no result is lost or duplicated.
5. Assert rst asynchronously while 3 results are in flight -> out_valid=0 immediately, no results emerge after release, and the next operation completes correctly.
6. DATA_W=32, SEG_W=8 (RES_W=11), rs=rt=32'hFFFFFFFF -> with sgn=0, rd=11'h7F8 and rd_ext=32'h000007F8; with sgn=1, rd_ext=32'hFFFFFFF8.

Source files
------------

// File: rtl/reduction_pipe_pkg.sv
// Shared constants and sizing helpers for the segment-sum reduction unit.
// Decode and writeback both size the result through res_w_f so they always agree.
package reduction_pipe_pkg;

    localparam logic [5:0] OP_RED = 6'h2D;

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int seg_cnt_f(input int data_w, input int seg_w);
        return (2 * data_w) / seg_w;
    endfunction

    // One extra bit per tree level is exactly enough for the worst-case sum.
    function automatic int res_w_f(input int data_w, input int seg_w);
        return seg_w + clog2_f(seg_cnt_f(data_w, seg_w));
    endfunction

endpackage

// File: rtl/reduction_pipe_if.sv
// Operand/result handshake bundle; master is the issuing side, slave is the unit.
interface reduction_pipe_if #(
    parameter int DATA_W = 16,
    parameter int SEG_W  = 4
);
    import reduction_pipe_pkg::*;

    localparam int RES_W = res_w_f(DATA_W, SEG_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic              sgn;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  rd;
    logic [DATA_W-1:0] rd_ext;

    modport master (
        output in_valid, rs, rt, sgn, out_ready,
        input  in_ready, out_valid, rd, rd_ext
    );

    modport slave (
        input  in_valid, rs, rt, sgn, out_ready,
        output in_ready, out_valid, rd, rd_ext
    );

endinterface

// File: rtl/reduction_pipe_add_level.sv
// One adder-tree level: registers pairwise sums of N_IN inputs plus valid/mode, 1 cycle.
// Holds everything when en_i is low; inputs are widened by one bit using the carried mode.
module red_add_level #(
    parameter int N_IN = 2,
    parameter int IN_W = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en_i,
    input  logic                              vld_i,
    input  logic                              mode_i,
    input  logic [N_IN*IN_W-1:0]              dat_i,
    output logic                              vld_o,
    output logic                              mode_o,
    output logic [(N_IN/2)*(IN_W+1)-1:0]      dat_o
);
    localparam int N_OUT = N_IN / 2;
    localparam int OUT_W = IN_W + 1;

    logic [N_OUT*OUT_W-1:0] sum_d;
    logic [N_OUT*OUT_W-1:0] sum_q;
    logic                   vld_q;
    logic                   mode_q;

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        logic [IN_W-1:0] a;
        logic [IN_W-1:0] b;
        assign a = dat_i[(2*j)*IN_W +: IN_W];
        assign b = dat_i[(2*j+1)*IN_W +: IN_W];
        // Sign- or zero-extend by one bit so the pair sum cannot overflow.
        assign sum_d[j*OUT_W +: OUT_W] = {mode_i & a[IN_W-1], a} + {mode_i & b[IN_W-1], b};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            vld_q  <= 1'b0;
            mode_q <= 1'b0;
        end else if (en_i) begin
            sum_q  <= sum_d;
            vld_q  <= vld_i;
            mode_q <= mode_i;
        end
    end

    assign dat_o  = sum_q;
    assign vld_o  = vld_q;
    assign mode_o = mode_q;

endmodule

// File: rtl/reduction_pipe.sv
// Pipelined sum of all SEG_W segments of rs and rt; latency L = clog2(2*DATA_W/SEG_W) cycles.
// Whole pipe stalls only when the final stage holds an unaccepted result; in_ready follows out_ready.
module reduction_pipe
    import reduction_pipe_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SEG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    reduction_pipe_if.slave  bus
);
    localparam int N     = seg_cnt_f(DATA_W, SEG_W);
    localparam int L     = clog2_f(N);
    localparam int RES_W = res_w_f(DATA_W, SEG_W);

    logic         advance;
    logic [L:0]   v;
    logic [L:0]   mode;

    assign v[0]    = bus.in_valid;
    assign mode[0] = bus.sgn;

    for (genvar k = 1; k <= L; k++) begin : g_lvl
        localparam int NI = N >> (k - 1);
        localparam int IW = SEG_W + k - 1;

        logic [NI*IW-1:0]         din;
        logic [(NI/2)*(IW+1)-1:0] dout;

        if (k == 1) begin : g_first
            // rs occupies segments 0..N/2-1, rt the upper half.
            assign din = {bus.rt, bus.rs};
        end else begin : g_next
            assign din = g_lvl[k-1].dout;
        end

        red_add_level #(
            .N_IN (NI),
            .IN_W (IW)
        ) u_lvl (
            .clk    (clk),
            .rst    (rst),
            .en_i   (advance),
            .vld_i  (v[k-1]),
            .mode_i (mode[k-1]),
            .dat_i  (din),
            .vld_o  (v[k]),
            .mode_o (mode[k]),
            .dat_o  (dout)
        );
    end

    assign advance      = !(v[L] && !bus.out_ready);
    assign bus.in_ready = advance;
    assign bus.out_valid = v[L];

    assign bus.rd     = g_lvl[L].dout;
    assign bus.rd_ext = mode[L] ? DATA_W'($signed(g_lvl[L].dout))
                                : DATA_W'(g_lvl[L].dout);

endmodule

// File: tb/tb_reduction_pipe.sv
// Directed bench for reduction_pipe at default and 32/8 parameterisations.
module tb_reduction_pipe;
    import reduction_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reduction_pipe_if #(.DATA_W(16), .SEG_W(4)) b0();
    reduction_pipe_if #(.DATA_W(32), .SEG_W(8)) b1();

    reduction_pipe #(.DATA_W(16), .SEG_W(4)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    reduction_pipe #(.DATA_W(32), .SEG_W(8)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

    // Signed/unsigned nibble sum as a plain integer; low bits give rd, low 16 give rd_ext.
    function automatic int ref_sum(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [31:0] both;
        logic [3:0]  nb;
        int          acc;
        both = {b, a};
        acc  = 0;
        for (int i = 0; i < 8; i++) begin
            nb = both[i*4 +: 4];
            if (s && nb[3]) acc = acc + int'(nb) - 16;
            else            acc = acc + int'(nb);
        end
        return acc;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        b0.in_valid = 1'b0; b0.rs = '0; b0.rt = '0; b0.sgn = 1'b0; b0.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.rs = '0; b1.rt = '0; b1.sgn = 1'b0; b1.out_ready = 1'b1;
        #12;
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", b0.out_valid); end
        checks++; if (b0.rd !== 7'd0) begin errors++; $display("FAIL reset_rd got %h want 0", b0.rd); end
        checks++; if (b0.rd_ext !== 16'h0000) begin errors++; $display("FAIL reset_rd_ext got %h want 0", b0.rd_ext); end
        checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL reset_wide_out_valid got %b want 0", b1.out_valid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", b0.in_ready); end
        checks++; if (b1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_wide_in_ready got %b want 1", b1.in_ready); end
    endtask

    task automatic test_latency();
        @(negedge clk);
        b0.in_valid = 1'b1; b0.rs = 16'h1234; b0.rt = 16'h5678; b0.sgn = 1'b0; b0.out_ready = 1'b1;
        @(negedge clk);
        b0.in_valid = 1'b0;
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL latency_c1 got %b want 0", b0.out_valid); end
        @(negedge clk);
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL latency_c2 got %b want 0", b0.out_valid); end
        @(negedge clk);
        checks++; if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL latency_c3 got %b want 1", b0.out_valid); end
        checks++; if (b0.rd !== 7'd36) begin errors++; $display("FAIL latency_rd got %h want 24", b0.rd); end
        checks++; if (b0.rd_ext !== 16'h0024) begin errors++; $display("FAIL latency_rd_ext got %h want 0024", b0.rd_ext); end
        @(negedge clk);
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL latency_drain got %b want 0", b0.out_valid); end
    endtask

    task automatic test_signed();
        logic [15:0] op[3]   = '{16'hFFFF, 16'hFFFF, 16'h8888};
        logic        sg[3]   = '{1'b0, 1'b1, 1'b1};
        logic [6:0]  e_rd[3] = '{7'h78, 7'h78, 7'h40};
        logic [15:0] e_ex[3] = '{16'h0078, 16'hFFF8, 16'hFFC0};
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                checks++; if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL signed_vld%0d got %b want 1", c-3, b0.out_valid); end
                checks++; if (b0.rd !== e_rd[c-3]) begin errors++; $display("FAIL signed_rd%0d got %h want %h", c-3, b0.rd, e_rd[c-3]); end
                checks++; if (b0.rd_ext !== e_ex[c-3]) begin errors++; $display("FAIL signed_ext%0d got %h want %h", c-3, b0.rd_ext, e_ex[c-3]); end
            end
            if (c < 3) begin
                b0.in_valid = 1'b1; b0.rs = op[c]; b0.rt = op[c]; b0.sgn = sg[c];
            end else begin
                b0.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL signed_drain got %b want 0", b0.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_v[8];
        int          e;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 3 && c < 11) begin
                checks++;
                if (b0.out_valid !== 1'b1 || b0.rd !== exp_v[c-3][6:0] || b0.rd_ext !== exp_v[c-3][15:0]) begin
                    errors++;
                    $display("FAIL b2b_res%0d got vld=%b rd=%h ext=%h want vld=1 rd=%h ext=%h",
                             c-3, b0.out_valid, b0.rd, b0.rd_ext, exp_v[c-3][6:0], exp_v[c-3][15:0]);
                end
            end else begin
                checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d got %b want 0", c, b0.out_valid); end
            end
            if (c < 8) begin
                b0.in_valid = 1'b1;
                b0.rs  = 16'($urandom);
                b0.rt  = 16'($urandom);
                b0.sgn = 1'($urandom_range(0, 1));
                e = ref_sum(b0.rs, b0.rt, b0.sgn);
                exp_v[c] = e;
            end else begin
                b0.in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        int          q[$];
        int          sent = 0;
        int          got  = 0;
        int          e;
        logic [31:0] ev;
        logic        last_take = 1'b1;
        logic        stalled   = 1'b0;
        logic        exp_rdy;
        logic [6:0]  held = '0;
        for (int c = 0; c < 40 && got < 10; c++) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (b0.out_valid !== 1'b1 || b0.rd !== held) begin
                    errors++; $display("FAIL bp_stable c%0d got vld=%b rd=%h want vld=1 rd=%h", c, b0.out_valid, b0.rd, held);
                end
            end
            b0.out_ready = !(c >= 4 && c < 9);
            if (last_take) begin
                if (sent < 10) begin
                    b0.in_valid = 1'b1;
                    b0.rs  = 16'($urandom);
                    b0.rt  = 16'($urandom);
                    b0.sgn = 1'($urandom_range(0, 1));
                end else begin
                    b0.in_valid = 1'b0;
                end
            end
            #1;
            exp_rdy = !(b0.out_valid && !b0.out_ready);
            checks++; if (b0.in_ready !== exp_rdy) begin errors++; $display("FAIL bp_in_ready c%0d got %b want %b", c, b0.in_ready, exp_rdy); end
            if (b0.out_valid && b0.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL bp_extra c%0d got rd=%h want no result", c, b0.rd);
                end else begin
                    e  = q.pop_front();
                    ev = e;
                    if (b0.rd !== ev[6:0] || b0.rd_ext !== ev[15:0]) begin
                        errors++; $display("FAIL bp_result%0d got rd=%h ext=%h want rd=%h ext=%h", got, b0.rd, b0.rd_ext, ev[6:0], ev[15:0]);
                    end
                end
                got++;
            end
            last_take = b0.in_valid && b0.in_ready;
            if (last_take) begin
                q.push_back(ref_sum(b0.rs, b0.rt, b0.sgn));
                sent++;
            end
            stalled = b0.out_valid && !b0.out_ready;
            held    = b0.rd;
        end
        b0.in_valid  = 1'b0;
        b0.out_ready = 1'b1;
        checks++; if (got !== 10) begin errors++; $display("FAIL bp_count got %0d want 10", got); end
        repeat (4) @(negedge clk);
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b want 0", b0.out_valid); end
    endtask

    task automatic test_reset_midflight();
        logic [15:0] op[3] = '{16'h1111, 16'h2222, 16'h3333};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            b0.in_valid = 1'b1; b0.rs = op[c]; b0.rt = op[c]; b0.sgn = 1'b0;
        end
        @(negedge clk);
        b0.in_valid = 1'b0;
        checks++; if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", b0.out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async got %b want 0", b0.out_valid); end
        checks++; if (b0.rd !== 7'd0) begin errors++; $display("FAIL rstmid_rd got %h want 0", b0.rd); end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost%0d got %b want 0", c, b0.out_valid); end
        end
        b0.in_valid = 1'b1; b0.rs = 16'h1234; b0.rt = 16'h5678; b0.sgn = 1'b1;
        @(negedge clk);
        b0.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_next_vld got %b want 1", b0.out_valid); end
        checks++; if (b0.rd !== 7'h14) begin errors++; $display("FAIL rstmid_next_rd got %h want 14", b0.rd); end
        checks++; if (b0.rd_ext !== 16'h0014) begin errors++; $display("FAIL rstmid_next_ext got %h want 0014", b0.rd_ext); end
        @(negedge clk);
    endtask

    task automatic test_wide();
        @(negedge clk);
        b1.in_valid = 1'b1; b1.rs = 32'hFFFFFFFF; b1.rt = 32'hFFFFFFFF; b1.sgn = 1'b0;
        @(negedge clk);
        b1.sgn = 1'b1;
        @(negedge clk);
        b1.in_valid = 1'b0;
        @(negedge clk);
        checks++; if (b1.out_valid !== 1'b1) begin errors++; $display("FAIL wide_u_vld got %b want 1", b1.out_valid); end
        checks++; if (b1.rd !== 11'h7F8) begin errors++; $display("FAIL wide_u_rd got %h want 7f8", b1.rd); end
        checks++; if (b1.rd_ext !== 32'h000007F8) begin errors++; $display("FAIL wide_u_ext got %h want 000007f8", b1.rd_ext); end
        @(negedge clk);
        checks++; if (b1.rd !== 11'h7F8) begin errors++; $display("FAIL wide_s_rd got %h want 7f8", b1.rd); end
        checks++; if (b1.rd_ext !== 32'hFFFFFFF8) begin errors++; $display("FAIL wide_s_ext got %h want fffffff8", b1.rd_ext); end
        @(negedge clk);
        checks++; if (b1.out_valid !== 1'b0) begin errors++; $display("FAIL wide_drain got %b want 0", b1.out_valid); end
    endtask

    initial begin
        #1;
        test_reset();
        test_latency();
        test_signed();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
